seg_scan: RTL
=============

// Module: seg_scan
// PURPOSE
//  Time-multiplexed scan driver for the 8-digit common-anode 7-segment display.
//  Holds a 32-bit display word (8 hex nibbles) and cycles through the digits one at a time.
//  For each digit it drives the active-low digit select ds and the 4-bit nibble plus dp to the seg decoder.
//  It inserts a dark interval between digits to prevent ghosting, and updates the display only at frame boundaries.
// PARAMETERS
//  SCAN_DIV   50000  clk cycles per digit slot (>= BLANK_CYC+1, >= 2)
//  BLANK_CYC  16     leading cycles of each slot with ds forced all-off (0 = no blanking)
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  val_in     in   32  display word; nibble i -> digit i (digit 0 rightmost)
//  dp_in      in   8   decimal points; bit i lights dp of digit i
//  val_load   in   1   1-cycle strobe: capture val_in/dp_in into pending regs
//  lz_en      in   1   1 = suppress leading zeros (level, sampled every cycle)
//  d_out      out  4   nibble of current digit -> seg decoder d_in
//  dp_out     out  1   1 = dp of current digit lit
//  ds         out  8   digit select, active-low; ds[i]=0 enables digit i
//  frame_start out 1   1-cycle pulse on entering slot 0 (shadow update cycle)
// BEHAVIOUR
//  - All outputs registered. Reset: ds=8'hFF, d_out=0, dp_out=0, frame_start=0;
//    idx=0, cnt=0, state=BLANK (SHOW if BLANK_CYC==0), pending=shadow=0, pend_vld=0.
//  - cnt counts 0..SCAN_DIV-1 within slot; idx counts digits 0..7, wraps 7->0.
//  - FSM BLANK: ds=8'hFF; at cnt==BLANK_CYC-1 -> SHOW. SHOW: ds=~(8'b1<<idx) unless digit blanked.
//    At cnt==SCAN_DIV-1 (any state): cnt<=0, idx<=idx+1, state<=BLANK (SHOW if BLANK_CYC==0).
//  - d_out/dp_out updated at slot start (cnt==0 cycle), held constant for whole slot.
//  - Frame boundary = the cycle idx goes 7->0. If pend_vld: shadow<=pending, pend_vld<=0.
//    frame_start=1 on the first cycle of slot 0 (also on first slot after reset).
//  - val_load: pending<={dp_in,val_in}, pend_vld<=1. Multiple loads per frame: last wins.
//    val_load on the boundary cycle itself: val_in/dp_in bypass straight to shadow,
//    and pend_vld ends 0.
//  - Leading-zero blank: if lz_en and idx!=0 and shadow nibbles idx..7 all zero, then
//    ds stays 8'hFF for that slot (timing unchanged), and dp_out=dp bit (unless blanked) -> 0.
//    Digit 0 is never blanked, so value 0 shows "0".
//  - lz_en change takes effect at next slot start; no mid-slot glitch on ds.
//  - rst mid-slot: next cycle exact reset state; pending load in the same cycle is discarded.
//  - Refresh rate = clk/(8*SCAN_DIV); duty per digit = (SCAN_DIV-BLANK_CYC)/(8*SCAN_DIV).
// STRUCTURE
//  - seg_pkg: NUM_DIG=8, DS_OFF=8'hFF, state encoding ST_BLANK/ST_SHOW, nibble type.
//  - One sub-module: seg_scan_tick (slot counter cnt + idx, emits slot_start, blank_end,
//    frame_wrap); seg_scan holds pending/shadow regs, LZ logic, FSM and output regs.
//  - Downstream: d_out -> seg.d_in, ds -> board digit enables, dp_out ORed into seg dp.
// TESTING (bench uses SCAN_DIV=8, BLANK_CYC=2)
//  1 rst 3 cycles, release -> ds=FF for cycles 0-1, then ds=FE for cycles 2-7, d_out=0,
//    frame_start=1 at cycle 0 only; next slot ds=FF,FF then FD.
//  2 val_load val_in=32'h76543210 mid-frame -> display unchanged until frame_start; next frame
//    slot i shows d_out=i with ds=~(1<<i); full frame = 64 cycles.
//  3 lz_en=1, value 32'h00000A05 -> digits 0,1,2 lit (5,0,A), slots 3-7 ds=FF for all 8 cycles;
//    value 0 -> only digit 0 lit with d_out=0.
//  4 dp_in=8'h04 -> dp_out=1 only during slot 2; with lz_en and value 0 dp_out=0 in slot 2.
//  5 val_load on the exact boundary cycle with 32'hDEADBEEF after earlier load of 32'h1 ->
//    new frame shows DEADBEEF; two loads in one frame (1 then 2) -> frame shows 2.
//  6 rst asserted during SHOW of slot 5 -> next cycle ds=FF, idx=0, shadow=0,
//    frame_start pulses on release.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared constants, state encoding and helpers for the 8-digit scan driver.
package seg_scan_pkg;

    localparam int         NUM_DIG = 8;
    localparam logic [7:0] DS_OFF  = 8'hFF;

    typedef logic [3:0] nibble_t;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // Nibble of digit i taken from a 32-bit display word.
    function automatic nibble_t nib_at(input logic [31:0] v, input logic [2:0] i);
        return v[{i, 2'b00} +: 4];
    endfunction

    // Active-low select pattern enabling only digit i.
    function automatic logic [7:0] digit_sel(input logic [2:0] i);
        return ~(8'b0000_0001 << i);
    endfunction

    // True when every nibble from digit i up to the top digit is zero.
    function automatic logic upper_zero(input logic [31:0] v, input logic [2:0] i);
        logic z;
        z = 1'b1;
        for (int k = 0; k < NUM_DIG; k++) begin
            if ((k >= int'(i)) && (v[k*4 +: 4] != 4'h0)) begin
                z = 1'b0;
            end
        end
        return z;
    endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Host-side bus of the scan driver: display word load plus the digit drive outputs.
interface seg_scan_if;

    logic [31:0] val_in;
    logic [7:0]  dp_in;
    logic        val_load;
    logic        lz_en;
    logic [3:0]  d_out;
    logic        dp_out;
    logic [7:0]  ds;
    logic        frame_start;

    modport master (
        output val_in, dp_in, val_load, lz_en,
        input  d_out, dp_out, ds, frame_start
    );

    modport slave (
        input  val_in, dp_in, val_load, lz_en,
        output d_out, dp_out, ds, frame_start
    );

endinterface

// File: rtl/seg_scan_tick.sv
// Slot timebase: cycle counter within a digit slot and the digit index,
// with decoded slot-start, end-of-blanking, end-of-slot and frame-wrap flags.
module seg_scan_tick
    import seg_scan_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] idx,
    output logic       slot_start,
    output logic       blank_end,
    output logic       slot_end,
    output logic       frame_wrap
);

    localparam int             CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int             BEND_INT = (BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0;
    localparam logic [CW-1:0]  CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  CNT_BEND = CW'(BEND_INT);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic           HAS_BLANK = (BLANK_CYC > 0);
    localparam logic [2:0]     LAST_DIG = 3'(NUM_DIG - 1);

    logic [CW-1:0] cnt_r;
    logic [2:0]    idx_r;

    // Slot counter and digit index; index advances (and wraps 7->0) at end of slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
            idx_r <= 3'd0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
            idx_r <= idx_r + 3'd1;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    assign idx        = idx_r;
    assign slot_start = (cnt_r == '0);
    assign blank_end  = HAS_BLANK && (cnt_r == CNT_BEND);
    assign slot_end   = (cnt_r == CNT_LAST);
    assign frame_wrap = (cnt_r == CNT_LAST) && (idx_r == LAST_DIG);

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed 8-digit common-anode display driver. Keeps a pending and a
// shadow copy of the display word; the shadow only changes at frame boundaries
// so a frame never shows a mix of old and new digits. Each slot begins with a
// dark interval to stop ghosting between neighbouring digits. All outputs are
// registered and lag the internal slot counter by one cycle.
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    seg_scan_if.slave bus
);

    localparam scan_state_e SLOT_ST = (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;

    logic [2:0]  idx_s;
    logic        slot_start_s;
    logic        blank_end_s;
    logic        slot_end_s;
    logic        frame_wrap_s;

    logic [39:0] pending_r;
    logic        pend_vld_r;
    logic [39:0] shadow_r;

    logic        blank_r;
    logic        blank_calc_s;
    logic        blank_now_s;

    scan_state_e state_r;
    scan_state_e state_nx_s;

    logic [7:0]  ds_nx_s;
    logic [3:0]  d_nx_s;
    logic        dp_nx_s;
    logic        fs_nx_s;

    logic [7:0]  ds_r;
    logic [3:0]  d_out_r;
    logic        dp_out_r;
    logic        fs_r;

    seg_scan_tick #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .idx        (idx_s),
        .slot_start (slot_start_s),
        .blank_end  (blank_end_s),
        .slot_end   (slot_end_s),
        .frame_wrap (frame_wrap_s)
    );

    // Pending/shadow display word: loads park in pending, shadow follows at the frame wrap;
    // a load landing on the wrap cycle itself goes straight to shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r  <= 40'h0;
            pend_vld_r <= 1'b0;
            shadow_r   <= 40'h0;
        end else if (frame_wrap_s) begin
            if (bus.val_load) begin
                shadow_r <= {bus.dp_in, bus.val_in};
            end else if (pend_vld_r) begin
                shadow_r <= pending_r;
            end else begin
                shadow_r <= shadow_r;
            end
            pend_vld_r <= 1'b0;
        end else if (bus.val_load) begin
            pending_r  <= {bus.dp_in, bus.val_in};
            pend_vld_r <= 1'b1;
        end else begin
            pending_r  <= pending_r;
            pend_vld_r <= pend_vld_r;
        end
    end

    // Leading-zero decision for the digit about to be shown; digit 0 always shows.
    always_comb begin
        blank_calc_s = bus.lz_en && (idx_s != 3'd0) && upper_zero(shadow_r[31:0], idx_s);
        if (slot_start_s) begin
            blank_now_s = blank_calc_s;
        end else begin
            blank_now_s = blank_r;
        end
    end

    // Freeze the blanking decision for the whole slot so lz_en cannot glitch ds mid-slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            blank_r <= 1'b0;
        end else if (slot_start_s) begin
            blank_r <= blank_calc_s;
        end else begin
            blank_r <= blank_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= SLOT_ST;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next state: dark interval then show; every slot restarts in the dark interval.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_BLANK: begin
                if (blank_end_s) begin
                    state_nx_s = ST_SHOW;
                end else begin
                    state_nx_s = ST_BLANK;
                end
            end
            ST_SHOW: begin
                state_nx_s = ST_SHOW;
            end
            default: begin
                state_nx_s = ST_BLANK;
            end
        endcase
        if (slot_end_s) begin
            state_nx_s = SLOT_ST;
        end else begin
            state_nx_s = state_nx_s;
        end
    end

    // FSM outputs: digit select from state, nibble/dp captured once per slot start.
    always_comb begin
        ds_nx_s = DS_OFF;
        d_nx_s  = d_out_r;
        dp_nx_s = dp_out_r;
        fs_nx_s = slot_start_s && (idx_s == 3'd0);
        case (state_r)
            ST_SHOW: begin
                if (blank_now_s) begin
                    ds_nx_s = DS_OFF;
                end else begin
                    ds_nx_s = digit_sel(idx_s);
                end
            end
            ST_BLANK: begin
                ds_nx_s = DS_OFF;
            end
            default: begin
                ds_nx_s = DS_OFF;
            end
        endcase
        if (slot_start_s) begin
            d_nx_s  = nib_at(shadow_r[31:0], idx_s);
            dp_nx_s = shadow_r[6'd32 + {3'd0, idx_s}] && !blank_calc_s;
        end else begin
            d_nx_s  = d_out_r;
            dp_nx_s = dp_out_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ds_r     <= DS_OFF;
            d_out_r  <= 4'h0;
            dp_out_r <= 1'b0;
            fs_r     <= 1'b0;
        end else begin
            ds_r     <= ds_nx_s;
            d_out_r  <= d_nx_s;
            dp_out_r <= dp_nx_s;
            fs_r     <= fs_nx_s;
        end
    end

    assign bus.ds          = ds_r;
    assign bus.d_out       = d_out_r;
    assign bus.dp_out      = dp_out_r;
    assign bus.frame_start = fs_r;

endmodule
